// File: rtl/disparity_wta_pkg.sv
// Shared census definitions for the stereo matching pipeline.
// Holds the default cost width and disparity count used by the
// population-count and winner-take-all stages, plus the WTA FSM states.
package disparity_wta_pkg;

    localparam int unsigned CENSUS_COST_WIDTH = 7;
    localparam int unsigned CENSUS_NUM_DISP   = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } wta_state_t;

endpackage

// File: rtl/disparity_wta_dff.sv
// Generic enabled register with synchronous active-high reset to zero.
// Ports:
//   en  - load enable (reset overrides it)
//   clk - clock, rising edge
//   rst - synchronous reset, clears q
//   d   - next value
//   q   - registered value
module dff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             en,
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selection. Consumes one matching cost per
// cycle (disparity index implied by arrival order, framed by cost_first)
// and reports the minimum-cost disparity with a uniqueness flag based on
// the gap to the runner-up cost.
// Ports:
//   en            - global pipeline enable, low freezes all state
//   clk, rst      - clock and synchronous active-high reset
//   cost_valid    - cost carries a candidate this cycle
//   cost_first    - candidate is disparity 0 of a new pixel
//   cost          - matching cost
//   out_valid     - one-cycle result strobe
//   out_disp      - winning disparity index
//   out_cost      - winning cost
//   out_confident - second-best minus best reached UNIQ_MARGIN
//   err_seq       - one-cycle framing-error strobe
module disparity_wta
    import disparity_wta_pkg::*;
#(
    parameter int unsigned COST_WIDTH  = CENSUS_COST_WIDTH,
    parameter int unsigned NUM_DISP    = CENSUS_NUM_DISP,
    parameter int unsigned UNIQ_MARGIN = 0,
    localparam int unsigned DISP_WIDTH = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1
) (
    input  logic                  en,
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cost_valid,
    input  logic                  cost_first,
    input  logic [COST_WIDTH-1:0] cost,
    output logic                  out_valid,
    output logic [DISP_WIDTH-1:0] out_disp,
    output logic [COST_WIDTH-1:0] out_cost,
    output logic                  out_confident,
    output logic                  err_seq
);

    localparam logic [DISP_WIDTH-1:0] LAST_IDX = DISP_WIDTH'(NUM_DISP - 1);
    localparam logic [COST_WIDTH:0]   MARGIN   = (COST_WIDTH + 1)'(UNIQ_MARGIN);
    localparam int unsigned           RES_W    = DISP_WIDTH + COST_WIDTH + 1;

    wta_state_t            r_state;
    logic [DISP_WIDTH-1:0] r_cnt;
    logic [DISP_WIDTH-1:0] r_best_d;
    logic [COST_WIDTH-1:0] r_best;
    logic [COST_WIDTH-1:0] r_second;

    wta_state_t            w_state_nxt;
    logic [DISP_WIDTH-1:0] w_cnt_nxt;
    logic [DISP_WIDTH-1:0] w_best_d_nxt;
    logic [COST_WIDTH-1:0] w_best_nxt;
    logic [COST_WIDTH-1:0] w_second_nxt;
    logic                  w_emit;
    logic                  w_err;
    logic [COST_WIDTH:0]   w_gap;
    logic                  w_conf;
    logic [RES_W-1:0]      w_res_d;
    logic [RES_W-1:0]      w_res_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_best_d_nxt = r_best_d;
        w_best_nxt   = r_best;
        w_second_nxt = r_second;
        w_emit       = 1'b0;
        w_err        = 1'b0;
        if (cost_valid) begin
            if (cost_first) begin
                // A first marker mid-pixel abandons the partial pixel and
                // restarts, flagging the framing break.
                w_err        = (r_state == ST_ACCUM);
                w_best_nxt   = cost;
                w_best_d_nxt = '0;
                w_second_nxt = '1;
                w_cnt_nxt    = DISP_WIDTH'(1);
                if (NUM_DISP == 1) begin
                    w_emit      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end else if (r_state == ST_IDLE) begin
                w_err = 1'b1;
            end else begin
                // Strict less-than keeps the lower disparity on ties; an
                // equal cost still becomes the runner-up.
                if (cost < r_best) begin
                    w_second_nxt = r_best;
                    w_best_nxt   = cost;
                    w_best_d_nxt = r_cnt;
                end else if (cost < r_second) begin
                    w_second_nxt = cost;
                end
                w_cnt_nxt = r_cnt + DISP_WIDTH'(1);
                if (r_cnt == LAST_IDX) begin
                    w_emit      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    // Extra bit keeps the gap non-negative; an untouched runner-up means
    // there was no competitor, which is always unique.
    assign w_gap   = {1'b0, w_second_nxt} - {1'b0, w_best_nxt};
    assign w_conf  = (&w_second_nxt) | (w_gap >= MARGIN);
    assign w_res_d = {w_best_d_nxt, w_best_nxt, w_conf};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_best_d <= '0;
            r_best   <= '1;
            r_second <= '1;
        end else if (en) begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_best_d <= w_best_d_nxt;
            r_best   <= w_best_nxt;
            r_second <= w_second_nxt;
        end
    end

    dff #(.WIDTH(1)) u_valid_reg (
        .en  (en),
        .clk (clk),
        .rst (rst),
        .d   (w_emit),
        .q   (out_valid)
    );

    dff #(.WIDTH(1)) u_err_reg (
        .en  (en),
        .clk (clk),
        .rst (rst),
        .d   (w_err),
        .q   (err_seq)
    );

    // Result fields only load on an emit so they hold between strobes.
    dff #(.WIDTH(RES_W)) u_res_reg (
        .en  (en & w_emit),
        .clk (clk),
        .rst (rst),
        .d   (w_res_d),
        .q   (w_res_q)
    );

    assign {out_disp, out_cost, out_confident} = w_res_q;

endmodule

// File: doc/disparity_wta.md
DISPARITY_WTA -- requirements
Module: disparity_wta

Interface
REQ-001 Parameter COST_WIDTH, default 7: width of one matching cost, i.e. one Hamming-distance word from the population-count stage.
REQ-002 Parameter NUM_DISP, default 64: number of disparity candidates per pixel (>=1).
REQ-003 Parameter UNIQ_MARGIN, default 0: minimum required (second_best - best) cost gap for a confident result; 0 = always confident.
REQ-004 Derived localparam DISP_WIDTH = max(1, $clog2(NUM_DISP)).
REQ-005 en  input  1  global pipeline enable; low freezes every register.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 cost_valid  input  1  cost carries a candidate this cycle.
REQ-009 cost_first  input  1  with cost_valid, marks the disparity-0 candidate of a new pixel.
REQ-010 cost  input  COST_WIDTH  matching cost, disparity index implied by arrival order.
REQ-011 out_valid  output  1  one-cycle result strobe (qualified by en).
REQ-012 out_disp  output  DISP_WIDTH  winning disparity index.
REQ-013 out_cost  output  COST_WIDTH  winning (minimum) cost.
REQ-014 out_confident  output  1  uniqueness test passed.
REQ-015 err_seq  output  1  one-cycle strobe on a framing error.

Function
REQ-016 All behaviour below applies only in cycles with en=1; en=0 holds all state and outputs unchanged.
REQ-017 FSM states IDLE and ACCUM; IDLE after reset.
REQ-018 IDLE: cost_valid&cost_first -> load best=cost, best_d=0, second=all-ones, cnt=1; go to ACCUM (or emit immediately per REQ-022 if NUM_DISP=1).
REQ-019 IDLE: cost_valid without cost_first -> sample discarded, err_seq=1 next cycle, stay IDLE.
REQ-020 ACCUM: cost_valid without cost_first -> if cost<best: second=best, best=cost, best_d=cnt; else if cost<second: second=cost; cnt+=1.
REQ-021 Ties resolve to the lower disparity (strict less-than); cost equal to best updates second to that cost.
REQ-022 On accepting candidate index NUM_DISP-1: out_valid=1 next cycle with out_disp/out_cost from the updated best, out_confident=(second-best>=UNIQ_MARGIN), FSM to IDLE; latency = 1 cycle after last cost.
REQ-023 ACCUM: cost_valid&cost_first -> err_seq=1 next cycle, partial pixel dropped with no out_valid, new pixel started per REQ-018.
REQ-024 cost_valid=0 cycles (bubbles) in ACCUM leave state unchanged; no timeout.
REQ-025 out_valid and err_seq are single-cycle pulses; out_disp/out_cost/out_confident hold their last values between strobes.
REQ-026 second-best arithmetic uses COST_WIDTH+1 bits; second=all-ones (no runner-up, NUM_DISP=1) always counts as confident.
REQ-027 A new pixel's cost_first may arrive the cycle after the last candidate of the previous pixel; full throughput of one candidate per cycle.

Reset
REQ-028 rst=1 (synchronous, overrides en) -> FSM=IDLE, cnt=0, best=all-ones, second=all-ones, out_valid=0, err_seq=0, out_disp=0, out_cost=0, out_confident=0.
REQ-029 rst mid-pixel discards the partial pixel; no out_valid, no err_seq results from it.

Structure
REQ-030 COST_WIDTH/NUM_DISP defaults and the IDLE/ACCUM state encodings live in the shared census package; not redefined locally.
REQ-031 Output registers use the existing dff sub-module (en, clk, rst, d, q); no other sub-module.
REQ-032 Target 120-400 lines of RTL; no latches, no combinational path from input to output.

Verification
REQ-033 NUM_DISP=4, costs 9,3,7,5 back-to-back -> one cycle after cost 5: out_valid=1, out_disp=1, out_cost=3.
REQ-034 Tie: costs 4,2,2,6 with UNIQ_MARGIN=1 -> out_disp=1, out_cost=2, out_confident=0.
REQ-035 Framing: costs 9,3 then cost_first with 8 -> err_seq pulse, no out_valid for first pixel; 8,1,9,9 -> out_disp=1, out_cost=1.
REQ-036 Stalls: en=0 and cost_valid=0 bubbles interleaved in 9,3,7,5 -> same result as REQ-033, out_valid held while en=0.
REQ-037 rst asserted after two candidates -> all outputs 0 next cycle; following full pixel 0,5,5,5 -> out_disp=0, out_confident=1 (margin 0).
REQ-038 Stray cost_valid without cost_first in IDLE -> err_seq=1 one cycle, no out_valid.
